// File: rtl/mem_bus_arbiter.sv
// Round-robin two-port arbiter and sequencer for a shared single-port 64-bit RAM bus.
// Only one transaction is in flight; out-of-window requests never reach the bus.
module mem_bus_arbiter #(
    parameter logic [31:0] BASE_ADDRESS  = 32'h0002_0000,
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter int unsigned READ_LATENCY  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [31:0] req0_addr,
    input  logic [63:0] req0_wdata,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [31:0] req1_addr,
    input  logic [63:0] req1_wdata,
    output logic        req0_ack,
    output logic        req1_ack,
    output logic        req0_done,
    output logic        req1_done,
    output logic        req0_err,
    output logic        req1_err,
    output logic [63:0] rdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    inout  wire  [63:0] mem_data
);

    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFF << ADDRESS_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last_grant;
    logic        r_port;
    logic [31:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic [2:0]  r_cnt;
    logic [1:0]  r_done;
    logic [1:0]  r_err;

    logic        w_grant_vld;
    logic        w_grant_port;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [63:0] w_sel_wdata;
    logic        w_hit;
    logic        w_accept;
    logic        w_to_resp;
    logic        w_resp_port;
    logic        w_resp_err;
    logic        w_drive;

    // On a tie the port that did not win last time gets the bus.
    always_comb begin
        w_grant_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            w_grant_port = ~r_last_grant;
        else
            w_grant_port = req1_valid;
    end

    assign w_sel_we    = w_grant_port ? req1_we    : req0_we;
    assign w_sel_addr  = w_grant_port ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant_port ? req1_wdata : req0_wdata;
    assign w_hit       = (w_sel_addr & ADDR_MASK) == (BASE_ADDRESS & ADDR_MASK);
    assign w_accept    = (r_state == S_IDLE) && w_grant_vld;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_vld) w_next = !w_hit ? S_RESP : (w_sel_we ? S_WRITE : S_READ);
            S_READ:  if (r_cnt == 3'd0) w_next = S_RESP;
            S_WRITE: w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ack    = 1'b0;
        req1_ack    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = 32'd0;
        w_drive     = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ack = w_grant_vld & ~w_grant_port;
                req1_ack = w_grant_vld &  w_grant_port;
            end
            S_READ: begin
                mem_read    = 1'b1;
                mem_address = r_addr;
            end
            S_WRITE: begin
                mem_write   = 1'b1;
                mem_address = r_addr;
                w_drive     = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_data = w_drive ? r_wdata : 64'bz;

    // A miss is the only path from IDLE straight into RESP, so it alone carries err.
    assign w_to_resp   = (w_next == S_RESP);
    assign w_resp_port = (r_state == S_IDLE) ? w_grant_port : r_port;
    assign w_resp_err  = (r_state == S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 64'd0;
            r_rdata      <= 64'd0;
            r_cnt        <= 3'd0;
            r_done       <= 2'b00;
            r_err        <= 2'b00;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant_port;
                r_port       <= w_grant_port;
                r_addr       <= w_sel_addr;
                r_wdata      <= w_sel_wdata;
                r_cnt        <= 3'(READ_LATENCY);
                if (!w_hit)
                    r_rdata <= 64'd0;
            end
            if (r_state == S_READ) begin
                if (r_cnt == 3'd0)
                    r_rdata <= mem_data;
                else
                    r_cnt <= r_cnt - 3'd1;
            end
            r_done[0] <= w_to_resp & ~w_resp_port;
            r_done[1] <= w_to_resp &  w_resp_port;
            r_err[0]  <= w_to_resp & w_resp_err & ~w_resp_port;
            r_err[1]  <= w_to_resp & w_resp_err &  w_resp_port;
        end
    end

    assign req0_done = r_done[0];
    assign req1_done = r_done[1];
    assign req0_err  = r_err[0];
    assign req1_err  = r_err[1];
    assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (read latency 1 and 3), each with its own RAM,
// checked against a transaction-level model of arbitration, timing and memory contents.
module tb_mem_bus_arbiter;

    localparam logic [31:0] BASE = 32'h0002_0000;
    localparam logic [31:0] MASK = 32'hFFFF_FC00;

    logic clock = 1'b0;
    logic reset_n;

    logic [1:0]       v0, v1, we0, we1;
    logic [1:0][31:0] a0, a1;
    logic [1:0][63:0] wd0, wd1;

    wire  [1:0]       ack0, ack1, dn0, dn1, er0, er1, mrd, mwr;
    wire  [1:0][63:0] rdat;
    wire  [1:0][31:0] madr;
    wire  [63:0]      md_a, md_b;

    logic [63:0] ram [2][128];
    logic [63:0] mdl [2][128];
    logic [63:0] rdm [2];
    logic        lastg [2];
    logic [1:0][3:0] rdc;

    int nchk, nfail;

    initial forever #5 clock = ~clock;

    mem_bus_arbiter #(.BASE_ADDRESS(BASE), .ADDRESS_WIDTH(10), .READ_LATENCY(1)) u_dut_l1 (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(v0[0]), .req0_we(we0[0]), .req0_addr(a0[0]), .req0_wdata(wd0[0]),
        .req1_valid(v1[0]), .req1_we(we1[0]), .req1_addr(a1[0]), .req1_wdata(wd1[0]),
        .req0_ack(ack0[0]), .req1_ack(ack1[0]), .req0_done(dn0[0]), .req1_done(dn1[0]),
        .req0_err(er0[0]), .req1_err(er1[0]), .rdata(rdat[0]), .mem_address(madr[0]),
        .mem_read(mrd[0]), .mem_write(mwr[0]), .mem_data(md_a)
    );

    mem_bus_arbiter #(.BASE_ADDRESS(BASE), .ADDRESS_WIDTH(10), .READ_LATENCY(3)) u_dut_l3 (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(v0[1]), .req0_we(we0[1]), .req0_addr(a0[1]), .req0_wdata(wd0[1]),
        .req1_valid(v1[1]), .req1_we(we1[1]), .req1_addr(a1[1]), .req1_wdata(wd1[1]),
        .req0_ack(ack0[1]), .req1_ack(ack1[1]), .req0_done(dn0[1]), .req1_done(dn1[1]),
        .req0_err(er0[1]), .req1_err(er1[1]), .rdata(rdat[1]), .mem_address(madr[1]),
        .mem_read(mrd[1]), .mem_write(mwr[1]), .mem_data(md_b)
    );

    // RAM models: data becomes valid only after the configured number of edges of mem_read,
    // and junk (inverted word) is presented before that.
    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            rdc[d] <= mrd[d] ? rdc[d] + 4'd1 : 4'd0;
            if (mwr[d])
                ram[d][madr[d][9:3]] <= (d == 1) ? md_b : md_a;
        end
    end

    assign md_a = mrd[0] ? ((rdc[0] >= 4'd1) ? ram[0][madr[0][9:3]] : ~ram[0][madr[0][9:3]]) : 64'bz;
    assign md_b = mrd[1] ? ((rdc[1] >= 4'd3) ? ram[1][madr[1][9:3]] : ~ram[1][madr[1][9:3]]) : 64'bz;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mdv(input int d);
        return (d == 1) ? md_b : md_a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input int d, input int p, input logic we, input logic [31:0] a,
                       input logic [63:0] wd);
        if (p == 0) begin
            v0[d] = 1'b1; we0[d] = we; a0[d] = a; wd0[d] = wd;
        end else begin
            v1[d] = 1'b1; we1[d] = we; a1[d] = a; wd1[d] = wd;
        end
    endtask

    task automatic rnd_req(input int d, input int p);
        logic [31:0] a;
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7)       a = BASE + 32'($urandom_range(0, 127) << 3);
        else if (r == 7) a = BASE + 32'd1024;
        else if (r == 8) a = BASE - 32'd8;
        else             a = $urandom;
        req(d, p, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    endtask

    // Called in an IDLE cycle just after inputs are set; returns in the following IDLE cycle.
    task automatic do_txn(input int d, input bit drop, input bit glitch);
        int          w, lat, last;
        logic [31:0] a;
        logic        we;
        logic [63:0] wd;
        bit          hit, erd, ewr;
        string       s;
        lat = (d == 1) ? 3 : 1;
        s   = (d == 1) ? "L3 " : "L1 ";
        #1;
        if (v0[d] && v1[d]) w = lastg[d] ? 0 : 1;
        else if (v0[d])     w = 0;
        else if (v1[d])     w = 1;
        else                w = -1;
        chk({s, "ack0"}, 64'(ack0[d]), 64'(w == 0));
        chk({s, "ack1"}, 64'(ack1[d]), 64'(w == 1));
        chk({s, "idle done"}, 64'({dn1[d], dn0[d]}), 64'd0);
        chk({s, "idle strobes"}, 64'({mrd[d], mwr[d]}), 64'd0);
        chk({s, "idle addr"}, 64'(madr[d]), 64'd0);
        if (w < 0) begin
            tick();
            return;
        end
        a  = (w == 1) ? a1[d]  : a0[d];
        we = (w == 1) ? we1[d] : we0[d];
        wd = (w == 1) ? wd1[d] : wd0[d];
        lastg[d] = (w == 1);
        hit  = (a & MASK) == (BASE & MASK);
        last = !hit ? 1 : (we ? 2 : lat + 2);
        for (int k = 1; k <= last; k++) begin
            tick();
            if (k == 1) begin
                if (drop) begin
                    if (w == 1) v1[d] = 1'b0; else v0[d] = 1'b0;
                end
                if (glitch) v1[d] = 1'b1;
            end
            if (k == last && glitch) v1[d] = 1'b0;
            erd = hit && !we && (k <= lat + 1);
            ewr = hit && we && (k == 1);
            chk({s, "mem_read"}, 64'(mrd[d]), 64'(erd));
            chk({s, "mem_write"}, 64'(mwr[d]), 64'(ewr));
            if (erd || ewr) chk({s, "mem_address"}, 64'(madr[d]), 64'(a));
            if (ewr) chk({s, "bus wdata"}, mdv(d), wd);
            chk({s, "done0"}, 64'(dn0[d]), 64'(k == last && w == 0));
            chk({s, "done1"}, 64'(dn1[d]), 64'(k == last && w == 1));
            chk({s, "err0"}, 64'(er0[d]), 64'(k == last && w == 0 && !hit));
            chk({s, "err1"}, 64'(er1[d]), 64'(k == last && w == 1 && !hit));
            if (k == last) begin
                if (!hit)     rdm[d] = 64'd0;
                else if (!we) rdm[d] = mdl[d][a[9:3]];
                chk({s, "rdata"}, rdat[d], rdm[d]);
            end
        end
        if (hit && we) mdl[d][a[9:3]] = wd;
        tick();
    endtask

    initial begin
        nchk = 0; nfail = 0;
        v0 = '0; v1 = '0; we0 = '0; we1 = '0; a0 = '0; a1 = '0; wd0 = '0; wd1 = '0;
        for (int d = 0; d < 2; d++) begin
            lastg[d] = 1'b1;
            rdm[d]   = 64'd0;
            for (int i = 0; i < 128; i++) begin
                ram[d][i] = {$urandom, $urandom};
                mdl[d][i] = ram[d][i];
            end
        end
        ram[0][2] = 64'hDEADBEEF_01234567;
        mdl[0][2] = 64'hDEADBEEF_01234567;
        reset_n = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("reset ack", 64'({ack1[d], ack0[d]}), 64'd0);
            chk("reset done", 64'({dn1[d], dn0[d]}), 64'd0);
            chk("reset err", 64'({er1[d], er0[d]}), 64'd0);
            chk("reset rdata", rdat[d], 64'd0);
            chk("reset strobes", 64'({mrd[d], mwr[d]}), 64'd0);
            chk("reset addr", 64'(madr[d]), 64'd0);
        end
        reset_n = 1'b1;
        tick();

        // port 1 alone reads a preloaded word
        req(0, 1, 1'b0, 32'h0002_0010, 64'd0);
        do_txn(0, 1, 0);

        // both ports held valid: grants alternate starting with port 0
        req(0, 0, 1'b1, BASE + 32'h20, 64'h1111_2222_3333_4444);
        req(0, 1, 1'b0, BASE + 32'h10, 64'd0);
        repeat (6) do_txn(0, 0, 0);
        v0[0] = 1'b0; v1[0] = 1'b0;

        // write then read back
        req(0, 0, 1'b1, 32'h0002_0008, 64'hA5A5_0000_FFFF_1234);
        do_txn(0, 1, 0);
        req(0, 0, 1'b0, 32'h0002_0008, 64'd0);
        do_txn(0, 1, 0);

        // out-of-window read
        req(0, 0, 1'b0, 32'h0003_0000, 64'd0);
        do_txn(0, 1, 0);

        // port 1 raises and drops valid while the bus is busy: never served
        req(0, 0, 1'b1, BASE + 32'h30, 64'h0BAD_F00D_CAFE_0001);
        do_txn(0, 1, 1);
        do_txn(0, 1, 0);

        // reset in the middle of a read
        req(0, 1, 1'b0, BASE + 32'h40, 64'd0);
        #1;
        chk("rst ack1", 64'(ack1[0]), 64'd1);
        tick();
        v1[0] = 1'b0;
        chk("rst mem_read before", 64'(mrd[0]), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst mem_read async", 64'(mrd[0]), 64'd0);
        chk("rst addr async", 64'(madr[0]), 64'd0);
        chk("rst rdata async", rdat[0], 64'd0);
        for (int d = 0; d < 2; d++) begin
            lastg[d] = 1'b1;
            rdm[d]   = 64'd0;
        end
        tick();
        chk("rst no done", 64'({dn1[0], dn0[0]}), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("rst no done after", 64'({dn1[0], dn0[0]}), 64'd0);
        req(0, 1, 1'b0, BASE + 32'h40, 64'd0);
        do_txn(0, 1, 0);

        // latency-3 instance: directed read plus window edges
        ram[1][5] = 64'h0123_4567_89AB_CDEF;
        mdl[1][5] = 64'h0123_4567_89AB_CDEF;
        req(1, 0, 1'b0, BASE + 32'h28, 64'd0);
        do_txn(1, 1, 0);
        req(1, 1, 1'b1, BASE + 32'd1016, 64'hFEED_0000_0000_BEEF);
        do_txn(1, 1, 0);
        req(1, 1, 1'b0, BASE + 32'd1016, 64'd0);
        do_txn(1, 1, 0);
        req(1, 0, 1'b0, BASE + 32'd1024, 64'd0);
        do_txn(1, 1, 0);
        req(1, 1, 1'b1, BASE - 32'd8, 64'h1234);
        do_txn(1, 1, 0);

        // random traffic on each instance
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                if (!v0[d] && $urandom_range(0, 1) == 1) rnd_req(d, 0);
                if (!v1[d] && $urandom_range(0, 1) == 1) rnd_req(d, 1);
                do_txn(d, 1, 0);
            end
            while (v0[d] || v1[d]) do_txn(d, 1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-port arbiter and sequencer for the shared single-port 64-bit RAM bus: 32-bit address, bidirectional 64-bit data, mem_read/mem_write strobes.
- Port 0 is the instruction-fetch side, port 1 the load/store side.
- The block arbitrates round-robin, range-checks the address, and runs exactly one RAM transaction at a time.
- It owns the bus-side tri-state drive and returns read data or an error to the winning port.

Parameters:
- BASE_ADDRESS, 32'h00020000, base of the RAM window.
- ADDRESS_WIDTH, 10, window size is 2^ADDRESS_WIDTH addresses; match mask = 32'hFFFFFFFF << ADDRESS_WIDTH.
- READ_LATENCY, 1, clock edges from mem_read assertion until RAM data is valid on mem_data (range 1..7).

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req0_valid, req1_valid  input  1  request pending; hold with fields stable until ack
- req0_we, req1_we  input  1  1 = write, 0 = read
- req0_addr, req1_addr  input  32  byte address
- req0_wdata, req1_wdata  input  64  write data
- req0_ack, req1_ack  output  1  combinational; high in the IDLE cycle the port is granted
- req0_done, req1_done  output  1  one-cycle completion pulse, registered
- req0_err, req1_err  output  1  valid with done; address outside window
- rdata  output  64  read data, valid with done, shared by both ports
- mem_address  output  32  RAM address
- mem_read  output  1  RAM read strobe
- mem_write  output  1  RAM write strobe
- mem_data  inout  64  RAM data bus

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset (async, reset_n=0), effective immediately:
  - state=IDLE; mem_read=0, mem_write=0; mem_data=Z; mem_address=0.
  - All ack/done/err=0; rdata=0; last_grant=1, so port 0 wins the first tie.
- Arbitration (IDLE only):
  - Only one valid: that port wins.
  - Both valid: the port != last_grant wins.
  - The winner's ack=1 for that cycle. On the edge, latch addr/we/wdata/port id and set last_grant=winner.
- Range check on the latched address, evaluated at the accept edge:
  - hit = (addr & mask) == (BASE_ADDRESS & mask).
  - Miss: go to RESP with err=1; no bus strobe is issued; rdata=0.
  - Hit with we=0: go to READ. Hit with we=1: go to WRITE.
- READ:
  - mem_address=latched addr; mem_read=1 for READ_LATENCY+1 cycles, driven by a down-counter.
  - mem_data sampled into rdata on the final edge, then go to RESP.
- WRITE:
  - mem_address=latched addr; mem_write=1; mem_data driven with wdata for exactly 1 cycle, then go to RESP.
- RESP:
  - done=1 and err on the latched port for one cycle; rdata held.
  - Go to IDLE. No arbitration occurs in RESP.
  - rdata keeps its value until the next read or error completion.
- Latency from valid sampled in IDLE (cycle 0): read done in cycle READ_LATENCY+2; write done in cycle 2; error done in cycle 1.
- Throughput: one transaction per (transaction length + 1) cycles; a port re-requesting immediately gets a fresh ack in the next IDLE.
- Invariants:
  - mem_read and mem_write never high together.
  - mem_data is driven only in WRITE, otherwise high-Z.
  - mem_address is stable for the whole strobe window; mem_address=0 in IDLE.
- valid dropped before ack: no transaction and no done.
- Reset during READ/WRITE: the transaction is aborted, strobes drop asynchronously, and no done is issued. A write aborted before its closing edge is not performed.

Test Plan:
- Port 1 alone reads 0x00020010 with RAM word = 64'hDEADBEEF_01234567, READ_LATENCY=1 -> ack1 in cycle 0; mem_read high cycles 1-2; done1 in cycle 3 with rdata = that word, err1=0.
- Port 0 writes 64'hA5A5_0000_FFFF_1234 to 0x00020008, then reads it back -> mem_write high one cycle with the bus driven; read returns the same value; mem_data is Z outside WRITE.
- Both ports valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1 starting with port 0; no strobe overlap; each done on the correct port.
- Port 0 reads 0x00030000 (outside window) -> no mem_read/mem_write; done0 plus err0 in cycle 1; rdata=0.
- Assert reset_n=0 mid-READ (cycle 1) -> mem_read drops without a clock edge; state IDLE; no done; the next request after release completes normally.
- READ_LATENCY=3 -> mem_read high for 4 cycles; done in cycle 5; captured data correct.
